// File: rtl/core_irq_ctrl.sv
// core_irq_ctrl: reset/NMI/N-way IRQ arbiter for the 2A03-class core.
// Samples on I_edge, decides on I_sync, supports NMI hijack of IRQ.
module core_irq_ctrl #(
  parameter int          N_IRQ    = 4,
  parameter logic [15:0] VEC_BASE = 16'hFFFA,
  parameter int          SRC_W    = (N_IRQ > 1) ? $clog2(N_IRQ) : 1
) (
  input  logic             I_clock,
  input  logic             I_reset,
  input  logic             I_edge,
  input  logic             I_sync,
  input  logic             I_nmi,
  input  logic [N_IRQ-1:0] I_irq,
  input  logic [N_IRQ-1:0] I_irq_en,
  input  logic             I_irq_mask,
  input  logic             I_ack,
  output logic             O_force_brk,
  output logic             O_irq_mask,
  output logic [15:0]      O_vec_addr_lo,
  output logic [15:0]      O_vec_addr_hi,
  output logic [SRC_W-1:0] O_src,
  output logic             O_src_valid,
  output logic [N_IRQ-1:0] O_pending
);

  localparam logic [15:0] VEC_NMI = VEC_BASE;
  localparam logic [15:0] VEC_RST = VEC_BASE + 16'd2;
  localparam logic [15:0] VEC_BRK = VEC_BASE + 16'd4;

  typedef enum logic [1:0] {
    S_RESET,
    S_IDLE,
    S_IRQ,
    S_NMI
  } state_t;

  state_t           state_q, state_d;
  logic             nmi_prev_q;
  logic             nmi_latch_q, nmi_latch_d;
  logic [N_IRQ-1:0] pend_q;
  logic [SRC_W-1:0] src_q, src_d;
  logic             srcv_q, srcv_d;
  logic [SRC_W-1:0] low_idx;
  logic             nmi_fall;
  logic             eff_nmi;

  assign nmi_fall = I_edge & nmi_prev_q & ~I_nmi;
  assign eff_nmi  = (state_q == S_NMI)
                  | ((state_q == S_IRQ) & nmi_latch_q);

  // Lowest-numbered pending channel wins.
  always_comb begin
    low_idx = '0;
    for (int i = N_IRQ - 1; i >= 0; i--) begin
      if (pend_q[i]) low_idx = SRC_W'(i);
    end
  end

  // Per-CPU-cycle input sampling, frozen while I_edge is low.
  always_ff @(posedge I_clock or negedge I_reset) begin
    if (!I_reset) begin
      nmi_prev_q <= 1'b1;
      pend_q     <= '0;
    end else if (I_edge) begin
      nmi_prev_q <= I_nmi;
      pend_q     <= ~I_irq & I_irq_en;
    end
  end

  // State, NMI latch and serviced-source registers.
  always_ff @(posedge I_clock or negedge I_reset) begin
    if (!I_reset) begin
      state_q     <= S_RESET;
      nmi_latch_q <= 1'b0;
      src_q       <= '0;
      srcv_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      nmi_latch_q <= nmi_latch_d;
      src_q       <= src_d;
      srcv_q      <= srcv_d;
    end
  end

  // Next state; a fresh NMI edge beats the ack-driven latch clear.
  always_comb begin
    state_d     = state_q;
    src_d       = src_q;
    srcv_d      = srcv_q;
    nmi_latch_d = nmi_latch_q;
    if (I_ack && eff_nmi) nmi_latch_d = 1'b0;
    if (nmi_fall) nmi_latch_d = 1'b1;
    unique case (state_q)
      S_RESET: begin
        if (I_ack) state_d = S_IDLE;
      end
      S_IDLE: begin
        if (I_sync) begin
          if (nmi_latch_q) begin
            state_d = S_NMI;
          end else if (|pend_q && !I_irq_mask) begin
            state_d = S_IRQ;
            src_d   = low_idx;
            srcv_d  = 1'b1;
          end
        end
      end
      default: begin
        if (I_ack) begin
          state_d = S_IDLE;
          srcv_d  = 1'b0;
        end
      end
    endcase
  end

  // Vector select: reset, NMI (incl. hijack), else IRQ/BRK.
  always_comb begin
    unique case (1'b1)
      state_q == S_RESET: O_vec_addr_lo = VEC_RST;
      eff_nmi:            O_vec_addr_lo = VEC_NMI;
      default:            O_vec_addr_lo = VEC_BRK;
    endcase
  end

  assign O_vec_addr_hi = O_vec_addr_lo + 16'd1;
  assign O_force_brk   = (state_q != S_IDLE);
  assign O_irq_mask    = (state_q != S_IDLE);
  assign O_src         = src_q;
  assign O_src_valid   = srcv_q;
  assign O_pending     = pend_q;

endmodule

// File: tb/tb_core_irq_ctrl.sv
// tb_core_irq_ctrl: directed plan plus random traffic,
// checked against a service-level model of the controller.
module tb_core_irq_ctrl;

  localparam int          N  = 4;
  localparam logic [15:0] VB = 16'hFFFA;

  localparam int K_RST  = 0;
  localparam int K_IDLE = 1;
  localparam int K_IRQ  = 2;
  localparam int K_NMI  = 3;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         I_edge, I_sync, I_nmi, I_irq_mask, I_ack;
  logic [N-1:0] I_irq, I_irq_en;
  logic         O_force_brk, O_irq_mask, O_src_valid;
  logic [15:0]  O_vec_addr_lo, O_vec_addr_hi;
  logic [1:0]   O_src;
  logic [N-1:0] O_pending;

  int n_run  = 0;
  int n_fail = 0;

  int           m_svc;
  bit           m_prev, m_latch, m_srcv;
  logic [N-1:0] m_pend;
  int           m_src;

  always #5 clk = ~clk;

  core_irq_ctrl #(.N_IRQ(N), .VEC_BASE(VB)) dut (
    .I_clock      (clk),
    .I_reset      (rst_n),
    .I_edge       (I_edge),
    .I_sync       (I_sync),
    .I_nmi        (I_nmi),
    .I_irq        (I_irq),
    .I_irq_en     (I_irq_en),
    .I_irq_mask   (I_irq_mask),
    .I_ack        (I_ack),
    .O_force_brk  (O_force_brk),
    .O_irq_mask   (O_irq_mask),
    .O_vec_addr_lo(O_vec_addr_lo),
    .O_vec_addr_hi(O_vec_addr_hi),
    .O_src        (O_src),
    .O_src_valid  (O_src_valid),
    .O_pending    (O_pending)
  );

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_run++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t",
               tag, got, exp, $time);
    end
  endtask

  function automatic int lowest(input logic [N-1:0] p);
    for (int i = 0; i < N; i++) if (p[i]) return i;
    return 0;
  endfunction

  task automatic model_reset();
    m_svc   = K_RST;
    m_prev  = 1'b1;
    m_latch = 1'b0;
    m_pend  = '0;
    m_src   = 0;
    m_srcv  = 1'b0;
  endtask

  function automatic logic [15:0] m_vec();
    if (m_svc == K_RST) return VB + 16'd2;
    if (m_svc == K_NMI || (m_svc == K_IRQ && m_latch)) return VB;
    return VB + 16'd4;
  endfunction

  task automatic model_clk();
    bit fall, nmi_vec, nl;
    int ns;
    fall    = I_edge && m_prev && !I_nmi;
    nmi_vec = (m_svc == K_NMI) || (m_svc == K_IRQ && m_latch);
    nl = m_latch;
    if (I_ack && nmi_vec) nl = 1'b0;
    if (fall) nl = 1'b1;
    ns = m_svc;
    if (m_svc == K_RST) begin
      if (I_ack) ns = K_IDLE;
    end else if (m_svc == K_IDLE) begin
      if (I_sync) begin
        if (m_latch) ns = K_NMI;
        else if (m_pend != 0 && !I_irq_mask) begin
          ns     = K_IRQ;
          m_src  = lowest(m_pend);
          m_srcv = 1'b1;
        end
      end
    end else if (I_ack) begin
      ns     = K_IDLE;
      m_srcv = 1'b0;
    end
    m_svc   = ns;
    m_latch = nl;
    if (I_edge) begin
      m_prev = I_nmi;
      m_pend = ~I_irq & I_irq_en;
    end
  endtask

  task automatic check_all();
    logic [15:0] vl, vh;
    vl = m_vec();
    vh = vl + 16'd1;
    chk("force_brk", O_force_brk, m_svc != K_IDLE);
    chk("irq_mask", O_irq_mask, m_svc != K_IDLE);
    chk("vec_lo", O_vec_addr_lo, vl);
    chk("vec_hi", O_vec_addr_hi, vh);
    chk("src", O_src, m_src);
    chk("src_valid", O_src_valid, m_srcv);
    chk("pending", O_pending, m_pend);
  endtask

  task automatic cyc(input bit e, input bit s, input bit a);
    I_edge = e;
    I_sync = s;
    I_ack  = a;
    @(posedge clk);
    model_clk();
    #1;
    check_all();
    I_edge = 1'b0;
    I_sync = 1'b0;
    I_ack  = 1'b0;
  endtask

  task automatic async_reset();
    #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    check_all();
    chk("rst_vec", O_vec_addr_lo, 16'hFFFC);
    chk("rst_srcv", O_src_valid, 1'b0);
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    int nmi_svc;
    rst_n      = 1'b0;
    I_edge     = 1'b0;
    I_sync     = 1'b0;
    I_ack      = 1'b0;
    I_nmi      = 1'b1;
    I_irq      = 4'hF;
    I_irq_en   = 4'hF;
    I_irq_mask = 1'b1;
    model_reset();
    #3;
    check_all();
    @(negedge clk);
    rst_n = 1'b1;

    // 1: reset sequence
    cyc(1, 0, 0);
    chk("t1_force", O_force_brk, 1'b1);
    chk("t1_lo", O_vec_addr_lo, 16'hFFFC);
    chk("t1_hi", O_vec_addr_hi, 16'hFFFD);
    cyc(1, 0, 1);
    chk("t1_idle_force", O_force_brk, 1'b0);
    chk("t1_idle_vec", O_vec_addr_lo, 16'hFFFE);

    // 2: level IRQ, channels 1,2 low
    I_irq      = 4'b1001;
    I_irq_mask = 1'b0;
    cyc(1, 0, 0);
    cyc(1, 1, 0);
    chk("t2_force", O_force_brk, 1'b1);
    chk("t2_lo", O_vec_addr_lo, 16'hFFFE);
    chk("t2_hi", O_vec_addr_hi, 16'hFFFF);
    chk("t2_src", O_src, 2'd1);
    chk("t2_srcv", O_src_valid, 1'b1);
    cyc(0, 0, 1);
    chk("t2_ack", O_force_brk, 1'b0);
    cyc(1, 1, 0);
    chk("t2_again", O_force_brk, 1'b1);
    cyc(0, 0, 1);

    // 3: masked and disabled
    I_irq      = 4'b1110;
    I_irq_mask = 1'b1;
    cyc(1, 0, 0);
    cyc(1, 1, 0);
    chk("t3_masked", O_force_brk, 1'b0);
    chk("t3_pend", O_pending, 4'b0001);
    I_irq_en = 4'b1110;
    cyc(1, 0, 0);
    chk("t3_dis", O_pending, 4'b0000);
    I_irq    = 4'hF;
    I_irq_en = 4'hF;

    // 4: one NMI per falling edge
    I_nmi   = 1'b0;
    nmi_svc = 0;
    cyc(1, 0, 0);
    for (int k = 0; k < 3; k++) begin
      cyc(1, 1, 0);
      if (O_force_brk) begin
        nmi_svc++;
        chk("t4_lo", O_vec_addr_lo, 16'hFFFA);
        chk("t4_hi", O_vec_addr_hi, 16'hFFFB);
        cyc(1, 0, 1);
      end
      cyc(1, 0, 0);
    end
    chk("t4_once", nmi_svc, 1);
    I_nmi = 1'b1;
    cyc(1, 0, 0);
    I_nmi = 1'b0;
    cyc(1, 0, 0);
    cyc(1, 1, 0);
    chk("t4_retrig", O_vec_addr_lo, 16'hFFFA);
    cyc(0, 0, 1);
    I_nmi = 1'b1;
    cyc(1, 0, 0);

    // 5: NMI hijacks IRQ sequence
    I_irq_mask = 1'b0;
    I_irq      = 4'b1011;
    cyc(1, 0, 0);
    cyc(1, 1, 0);
    chk("t5_irq_vec", O_vec_addr_lo, 16'hFFFE);
    chk("t5_src", O_src, 2'd2);
    cyc(1, 0, 0);
    I_nmi = 1'b0;
    cyc(1, 0, 0);
    chk("t5_hijack", O_vec_addr_lo, 16'hFFFA);
    chk("t5_srcv", O_src_valid, 1'b1);
    cyc(0, 0, 1);
    chk("t5_ack", O_force_brk, 1'b0);
    I_irq = 4'hF;
    cyc(1, 0, 0);
    cyc(1, 1, 0);
    chk("t5_no_nmi", O_force_brk, 1'b0);

    // 6: reset mid-IRQ
    I_nmi = 1'b1;
    I_irq = 4'b1110;
    cyc(1, 0, 0);
    cyc(1, 1, 0);
    I_nmi = 1'b0;
    cyc(1, 0, 0);
    chk("t6_hijack", O_vec_addr_lo, 16'hFFFA);
    I_nmi = 1'b1;
    async_reset();
    I_irq = 4'hF;
    cyc(1, 0, 1);
    cyc(1, 1, 0);
    chk("t6_latch_clr", O_force_brk, 1'b0);

    // random traffic
    for (int k = 0; k < 3000; k++) begin
      if ($urandom_range(0, 7) == 0) I_nmi = ~I_nmi;
      if ($urandom_range(0, 5) == 0) I_irq = 4'($urandom);
      if ($urandom_range(0, 15) == 0) I_irq_en = 4'($urandom);
      if ($urandom_range(0, 9) == 0) I_irq_mask = ~I_irq_mask;
      cyc(1'($urandom), $urandom_range(0, 3) == 0,
          $urandom_range(0, 4) == 0);
      if ($urandom_range(0, 299) == 0) async_reset();
    end

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
